axis_arb_mux_2x1: RTL and testbench



---
 rtl/axis_arb_mux_2x1.sv | 254 +++++++++++++++++++++++++
 tb/tb_axis_arb_mux_2x1.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_arb_mux_2x1.sv
// axis_arb_mux_2x1: 2:1 AXI4-Stream merge with round-robin arbitration and a
// registered 2-entry skid buffer on the master side.
//
// Ports
//   aclk            clock
//   areset          synchronous reset, active-high
//   s0_axis_*       slave port 0 (tdata/tvalid/tready/tuser/tlast/tstrb/tkeep/tdest)
//   s1_axis_*       slave port 1 (same set)
//   m0_axis_*       merged master stream (tdata/tvalid/tready/tuser/tlast/tstrb/tkeep/tdest)
//   m0_axis_tid     source index of the beat on m0 (0 = s0, 1 = s1)
//
// Optional feature
//   AXIS_ARB_PKT_LOCK_EN  when defined, a granted source keeps the output until
//                         its tlast beat is accepted (LOCK0/LOCK1 states). When
//                         undefined, arbitration happens on every accepted beat
//                         and tlast is only passed through.
//
// Timing
//   Every m0 output comes straight from the skid head register, so there is no
//   combinational path from any slave input to m0. Slave tready is built from a
//   registered "not full" flag, so m0_axis_tready never reaches s*_axis_tready
//   combinationally. A beat accepted in cycle N is presented on m0 in cycle N+1.
module axis_arb_mux_2x1 #(
  parameter int unsigned DATAW = 24
) (
  input  logic               aclk,
  input  logic               areset,

  input  logic [DATAW-1:0]   s0_axis_tdata,
  input  logic               s0_axis_tvalid,
  output logic               s0_axis_tready,
  input  logic               s0_axis_tuser,
  input  logic               s0_axis_tlast,
  input  logic [DATAW/8-1:0] s0_axis_tstrb,
  input  logic [DATAW/8-1:0] s0_axis_tkeep,
  input  logic               s0_axis_tdest,

  input  logic [DATAW-1:0]   s1_axis_tdata,
  input  logic               s1_axis_tvalid,
  output logic               s1_axis_tready,
  input  logic               s1_axis_tuser,
  input  logic               s1_axis_tlast,
  input  logic [DATAW/8-1:0] s1_axis_tstrb,
  input  logic [DATAW/8-1:0] s1_axis_tkeep,
  input  logic               s1_axis_tdest,

  output logic [DATAW-1:0]   m0_axis_tdata,
  output logic               m0_axis_tvalid,
  input  logic               m0_axis_tready,
  output logic               m0_axis_tuser,
  output logic               m0_axis_tlast,
  output logic [DATAW/8-1:0] m0_axis_tstrb,
  output logic [DATAW/8-1:0] m0_axis_tkeep,
  output logic               m0_axis_tdest,
  output logic               m0_axis_tid
);

  localparam int unsigned StrbW = DATAW / 8;

  typedef struct packed {
    logic [DATAW-1:0] data;
    logic             user;
    logic             last;
    logic [StrbW-1:0] strb;
    logic [StrbW-1:0] keep;
    logic             dest;
    logic             tid;
  } beat_t;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic rr_q, rr_d;          // index of the source that won last; ties go to !rr
  logic idle_gnt_vld;
  logic idle_gnt_idx;
  logic gnt_vld;
  logic gnt_idx;
  logic ready_q, ready_d;    // registered "skid not full"
  logic accept;
  logic sel_last;

  // Grant used when no packet is in flight.
  always_comb begin
    idle_gnt_vld = s0_axis_tvalid | s1_axis_tvalid;
    idle_gnt_idx = 1'b0;
    if (s0_axis_tvalid && s1_axis_tvalid) begin
      idle_gnt_idx = ~rr_q;
    end else if (s1_axis_tvalid) begin
      idle_gnt_idx = 1'b1;
    end
  end

`ifdef AXIS_ARB_PKT_LOCK_EN
  typedef enum logic [1:0] {StIdle, StLock0, StLock1} arb_state_e;

  arb_state_e state_q, state_d;

  // While locked the grant is held even if the source drops tvalid mid-packet.
  always_comb begin
    gnt_vld = idle_gnt_vld;
    gnt_idx = idle_gnt_idx;
    unique case (state_q)
      StLock0: begin
        gnt_vld = 1'b1;
        gnt_idx = 1'b0;
      end
      StLock1: begin
        gnt_vld = 1'b1;
        gnt_idx = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    if (accept) begin
      if (sel_last) begin
        state_d = StIdle;
        rr_d    = gnt_idx;
      end else begin
        state_d = gnt_idx ? StLock1 : StLock0;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end
`else
  assign gnt_vld = idle_gnt_vld;
  assign gnt_idx = idle_gnt_idx;

  // Re-arbitrate on every accepted beat.
  always_comb begin
    rr_d = rr_q;
    if (accept) begin
      rr_d = gnt_idx;
    end
  end
`endif

  always_ff @(posedge aclk) begin
    if (areset) begin
      rr_q <= 1'b1;
    end else begin
      rr_q <= rr_d;
    end
  end

  // areset gating keeps both readies low during the reset cycle itself, when
  // ready_q may still hold its pre-reset value.
  assign s0_axis_tready = ~areset & ready_q & gnt_vld & ~gnt_idx;
  assign s1_axis_tready = ~areset & ready_q & gnt_vld &  gnt_idx;

  assign accept   = gnt_idx ? (s1_axis_tvalid & s1_axis_tready)
                            : (s0_axis_tvalid & s0_axis_tready);
  assign sel_last = gnt_idx ? s1_axis_tlast : s0_axis_tlast;

  // ---------------------------------------------------------------------------
  // Input beat selection
  // ---------------------------------------------------------------------------
  beat_t in_beat;

  always_comb begin
    if (gnt_idx) begin
      in_beat.data = s1_axis_tdata;
      in_beat.user = s1_axis_tuser;
      in_beat.last = s1_axis_tlast;
      in_beat.strb = s1_axis_tstrb;
      in_beat.keep = s1_axis_tkeep;
      in_beat.dest = s1_axis_tdest;
    end else begin
      in_beat.data = s0_axis_tdata;
      in_beat.user = s0_axis_tuser;
      in_beat.last = s0_axis_tlast;
      in_beat.strb = s0_axis_tstrb;
      in_beat.keep = s0_axis_tkeep;
      in_beat.dest = s0_axis_tdest;
    end
    in_beat.tid = gnt_idx;
  end

  // ---------------------------------------------------------------------------
  // 2-entry skid buffer; ent0 is the head and drives m0 directly
  // ---------------------------------------------------------------------------
  beat_t      ent0_q, ent0_d;
  beat_t      ent1_q, ent1_d;
  logic [1:0] cnt_q, cnt_d;
  logic       push;
  logic       pop;

  assign push = accept;
  assign pop  = (cnt_q != 2'd0) & m0_axis_tready;

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    unique case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) begin
          ent0_d = in_beat;
        end else begin
          ent1_d = in_beat;
        end
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      // Only reachable with one entry held: ready is low when full.
      2'b11: begin
        ent0_d = in_beat;
      end
      default: ;
    endcase
  end

  // Ready for the next cycle is "not full" of the next occupancy, so it stays
  // low for one cycle after reset and never depends on m0_axis_tready
  // combinationally.
  assign ready_d = (cnt_d != 2'd2);

  always_ff @(posedge aclk) begin
    if (areset) begin
      ent0_q  <= '0;
      ent1_q  <= '0;
      cnt_q   <= 2'd0;
      ready_q <= 1'b0;
    end else begin
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  assign m0_axis_tvalid = (cnt_q != 2'd0);
  assign m0_axis_tdata  = ent0_q.data;
  assign m0_axis_tuser  = ent0_q.user;
  assign m0_axis_tlast  = ent0_q.last;
  assign m0_axis_tstrb  = ent0_q.strb;
  assign m0_axis_tkeep  = ent0_q.keep;
  assign m0_axis_tdest  = ent0_q.dest;
  assign m0_axis_tid    = ent0_q.tid;

endmodule

// File: tb/tb_axis_arb_mux_2x1.sv
// Bench for axis_arb_mux_2x1: randomized sources, scoreboard of expected m0
// beats, and a reference arbiter model working on queues of pending beats.
module tb_axis_arb_mux_2x1;

  localparam int unsigned DATAW = 24;
  localparam int unsigned SW    = DATAW / 8;

  typedef struct packed {
    logic [DATAW-1:0] data;
    logic             user;
    logic             last;
    logic [SW-1:0]    strb;
    logic [SW-1:0]    keep;
    logic             dest;
    logic             tid;
  } beat_t;

  logic             aclk = 1'b0;
  logic             areset;
  logic [DATAW-1:0] s0_axis_tdata, s1_axis_tdata, m0_axis_tdata;
  logic             s0_axis_tvalid, s1_axis_tvalid, m0_axis_tvalid;
  logic             s0_axis_tready, s1_axis_tready, m0_axis_tready;
  logic             s0_axis_tuser, s1_axis_tuser, m0_axis_tuser;
  logic             s0_axis_tlast, s1_axis_tlast, m0_axis_tlast;
  logic [SW-1:0]    s0_axis_tstrb, s1_axis_tstrb, m0_axis_tstrb;
  logic [SW-1:0]    s0_axis_tkeep, s1_axis_tkeep, m0_axis_tkeep;
  logic             s0_axis_tdest, s1_axis_tdest, m0_axis_tdest;
  logic             m0_axis_tid;

  axis_arb_mux_2x1 #(.DATAW(DATAW)) dut (
    .aclk           (aclk),
    .areset         (areset),
    .s0_axis_tdata  (s0_axis_tdata),
    .s0_axis_tvalid (s0_axis_tvalid),
    .s0_axis_tready (s0_axis_tready),
    .s0_axis_tuser  (s0_axis_tuser),
    .s0_axis_tlast  (s0_axis_tlast),
    .s0_axis_tstrb  (s0_axis_tstrb),
    .s0_axis_tkeep  (s0_axis_tkeep),
    .s0_axis_tdest  (s0_axis_tdest),
    .s1_axis_tdata  (s1_axis_tdata),
    .s1_axis_tvalid (s1_axis_tvalid),
    .s1_axis_tready (s1_axis_tready),
    .s1_axis_tuser  (s1_axis_tuser),
    .s1_axis_tlast  (s1_axis_tlast),
    .s1_axis_tstrb  (s1_axis_tstrb),
    .s1_axis_tkeep  (s1_axis_tkeep),
    .s1_axis_tdest  (s1_axis_tdest),
    .m0_axis_tdata  (m0_axis_tdata),
    .m0_axis_tvalid (m0_axis_tvalid),
    .m0_axis_tready (m0_axis_tready),
    .m0_axis_tuser  (m0_axis_tuser),
    .m0_axis_tlast  (m0_axis_tlast),
    .m0_axis_tstrb  (m0_axis_tstrb),
    .m0_axis_tkeep  (m0_axis_tkeep),
    .m0_axis_tdest  (m0_axis_tdest),
    .m0_axis_tid    (m0_axis_tid)
  );

  always #5 aclk = ~aclk;

  int unsigned total;
  int unsigned bad;
  int unsigned p0, p1, pm;   // valid / master-ready probabilities in percent
  beat_t       src0_q[$];
  beat_t       src1_q[$];
  beat_t       exp_q[$];     // beats accepted but not yet seen leaving m0
  beat_t       out_log[$];   // beats seen leaving m0, in order

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic beat_t mk(input logic [DATAW-1:0] d, input logic last);
    beat_t b;
    b.data = d;
    b.user = 1'($urandom);
    b.last = last;
    b.strb = SW'($urandom);
    b.keep = SW'($urandom);
    b.dest = 1'($urandom);
    b.tid  = 1'b0;
    return b;
  endfunction

  // Sources hold tvalid once raised until the beat is taken (AXIS rule);
  // between beats they idle with probability 100-p.
  task automatic refresh(input logic f0, input logic f1);
    if (src0_q.size() == 0) s0_axis_tvalid = 1'b0;
    else if (!s0_axis_tvalid || f0) s0_axis_tvalid = ($urandom_range(99) < p0);
    if (src0_q.size() != 0) begin
      s0_axis_tdata = src0_q[0].data;
      s0_axis_tuser = src0_q[0].user;
      s0_axis_tlast = src0_q[0].last;
      s0_axis_tstrb = src0_q[0].strb;
      s0_axis_tkeep = src0_q[0].keep;
      s0_axis_tdest = src0_q[0].dest;
    end
    if (src1_q.size() == 0) s1_axis_tvalid = 1'b0;
    else if (!s1_axis_tvalid || f1) s1_axis_tvalid = ($urandom_range(99) < p1);
    if (src1_q.size() != 0) begin
      s1_axis_tdata = src1_q[0].data;
      s1_axis_tuser = src1_q[0].user;
      s1_axis_tlast = src1_q[0].last;
      s1_axis_tstrb = src1_q[0].strb;
      s1_axis_tkeep = src1_q[0].keep;
      s1_axis_tdest = src1_q[0].dest;
    end
    m0_axis_tready = ($urandom_range(99) < pm);
  endtask

  task automatic cycle();
    logic f0, f1;
    @(negedge aclk);
    f0 = s0_axis_tvalid & s0_axis_tready;
    f1 = s1_axis_tvalid & s1_axis_tready;
    @(posedge aclk);
    #1;
    if (f0 && src0_q.size() != 0) void'(src0_q.pop_front());
    if (f1 && src1_q.size() != 0) void'(src1_q.pop_front());
    refresh(f0, f1);
  endtask

  task automatic do_reset(input int n);
    areset = 1'b1;
    src0_q.delete();
    src1_q.delete();
    repeat (n) cycle();
    areset = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((src0_q.size() != 0 || src1_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      cycle();
      n++;
    end
    if (src0_q.size() + src1_q.size() + exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s drain timeout: %0d beats left, want 0", name,
               src0_q.size() + src1_q.size() + exp_q.size());
    end
    repeat (2) cycle();
  endtask

  // Reference model: arbitration from the rules (lock owner, else single
  // valid, else the source that did not win last), readiness from scoreboard
  // occupancy, and every m0 beat checked against the scoreboard head.
  task automatic monitor();
    int    g;
    int    lock;
    logic  rr;
    logic  rdy;
    logic  pst;
    logic  gv;
    beat_t got;
    beat_t nb;
    lock = -1;
    rr   = 1'b1;
    pst  = 1'b1;
    forever begin
      @(negedge aclk);
      got.data = m0_axis_tdata;
      got.user = m0_axis_tuser;
      got.last = m0_axis_tlast;
      got.strb = m0_axis_tstrb;
      got.keep = m0_axis_tkeep;
      got.dest = m0_axis_tdest;
      got.tid  = m0_axis_tid;
      if (areset) begin
        chk("rst_s0_tready", 64'(s0_axis_tready), 64'd0);
        chk("rst_s1_tready", 64'(s1_axis_tready), 64'd0);
        exp_q.delete();
        lock = -1;
        rr   = 1'b1;
        pst  = 1'b1;
      end else begin
        g = -1;
        if (lock >= 0) g = lock;
        else if (s0_axis_tvalid && s1_axis_tvalid) g = rr ? 0 : 1;
        else if (s0_axis_tvalid) g = 0;
        else if (s1_axis_tvalid) g = 1;
        rdy = !pst && (exp_q.size() < 2);
        chk("s0_tready", 64'(s0_axis_tready), 64'(rdy && g == 0));
        chk("s1_tready", 64'(s1_axis_tready), 64'(rdy && g == 1));
        chk("m0_tvalid", 64'(m0_axis_tvalid), 64'(exp_q.size() > 0));
        if (pst) chk("rst_m0_zero", 64'(got), 64'd0);
        if (exp_q.size() != 0) begin
          chk("m0_beat", 64'(got), 64'(exp_q[0]));
          if (m0_axis_tready) begin
            out_log.push_back(got);
            void'(exp_q.pop_front());
          end
        end
        gv = (g == 0) ? s0_axis_tvalid : s1_axis_tvalid;
        if (g >= 0 && rdy && gv) begin
          if (g == 0) begin
            nb.data = s0_axis_tdata;
            nb.user = s0_axis_tuser;
            nb.last = s0_axis_tlast;
            nb.strb = s0_axis_tstrb;
            nb.keep = s0_axis_tkeep;
            nb.dest = s0_axis_tdest;
          end else begin
            nb.data = s1_axis_tdata;
            nb.user = s1_axis_tuser;
            nb.last = s1_axis_tlast;
            nb.strb = s1_axis_tstrb;
            nb.keep = s1_axis_tkeep;
            nb.dest = s1_axis_tdest;
          end
          nb.tid = 1'(g);
          exp_q.push_back(nb);
`ifdef AXIS_ARB_PKT_LOCK_EN
          if (nb.last) begin
            lock = -1;
            rr   = 1'(g);
          end else begin
            lock = g;
          end
`else
          rr = 1'(g);
`endif
        end
        pst = 1'b0;
      end
    end
  endtask

  initial begin
    int n;
    int unsigned tag0, tag1;
    total = 0;
    bad   = 0;
    p0 = 100;
    p1 = 100;
    pm = 100;
    areset         = 1'b1;
    s0_axis_tvalid = 1'b0;
    s1_axis_tvalid = 1'b0;
    m0_axis_tready = 1'b0;
    {s0_axis_tdata, s0_axis_tuser, s0_axis_tlast, s0_axis_tstrb, s0_axis_tkeep} = '0;
    {s1_axis_tdata, s1_axis_tuser, s1_axis_tlast, s1_axis_tstrb, s1_axis_tkeep} = '0;
    s0_axis_tdest = 1'b0;
    s1_axis_tdest = 1'b0;
    fork
      monitor();
    join_none

    // Single 4-beat packet from s0.
    do_reset(3);
    out_log.delete();
    for (int i = 1; i <= 4; i++) src0_q.push_back(mk(DATAW'(i), i == 4));
    refresh(1'b0, 1'b0);
    drain("t1", 100);
    chk("t1_count", 64'(out_log.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_data", 64'(out_log[i].data), 64'(i + 1));
      chk("t1_tid", 64'(out_log[i].tid), 64'd0);
      chk("t1_last", 64'(out_log[i].last), 64'(i == 3));
    end

`ifdef AXIS_ARB_PKT_LOCK_EN
    // Two packets contending from the first cycle after reset.
    do_reset(2);
    out_log.delete();
    for (int i = 0; i < 3; i++) begin
      src0_q.push_back(mk(DATAW'(32'hA0 + i), i == 2));
      src1_q.push_back(mk(DATAW'(32'hB0 + i), i == 2));
    end
    refresh(1'b0, 1'b0);
    drain("t2", 100);
    chk("t2_count", 64'(out_log.size()), 64'd6);
    for (int i = 0; i < 6; i++) begin
      chk("t2_tid", 64'(out_log[i].tid), 64'(i >= 3));
      chk("t2_data", 64'(out_log[i].data), (i < 3) ? 64'(32'hA0 + i) : 64'(32'hB0 + i - 3));
    end

    // s0 shows up while s1 is mid-packet.
    do_reset(2);
    out_log.delete();
    for (int i = 0; i < 4; i++) src1_q.push_back(mk(DATAW'(32'h400 + i), i == 3));
    refresh(1'b0, 1'b0);
    n = 0;
    while (src1_q.size() > 3 && n < 50) begin
      cycle();
      n++;
    end
    for (int i = 0; i < 2; i++) src0_q.push_back(mk(DATAW'(32'h500 + i), i == 1));
    refresh(1'b0, 1'b0);
    drain("t6", 100);
    chk("t6_count", 64'(out_log.size()), 64'd6);
    for (int i = 0; i < 6; i++) chk("t6_tid", 64'(out_log[i].tid), 64'(i < 4));
`else
    // Both sources continuously valid without tlast: strict interleave.
    do_reset(2);
    out_log.delete();
    for (int i = 0; i < 8; i++) begin
      src0_q.push_back(mk(DATAW'(32'h600 + i), 1'b0));
      src1_q.push_back(mk(DATAW'(32'h700 + i), 1'b0));
    end
    refresh(1'b0, 1'b0);
    drain("t5", 100);
    chk("t5_count", 64'(out_log.size()), 64'd16);
    for (int i = 0; i < 16; i++) begin
      chk("t5_tid", 64'(out_log[i].tid), 64'(i % 2));
      chk("t5_data", 64'(out_log[i].data),
          (i % 2 == 1) ? 64'(32'h700 + i / 2) : 64'(32'h600 + i / 2));
    end
`endif

    // Continuous s0 stream against a stalling master.
    do_reset(2);
    out_log.delete();
    pm = 45;
    for (int i = 0; i < 20; i++) src0_q.push_back(mk(DATAW'(32'h800 + i), i % 5 == 4));
    refresh(1'b0, 1'b0);
    drain("t3", 400);
    chk("t3_count", 64'(out_log.size()), 64'd20);
    for (int i = 0; i < 20; i++) chk("t3_data", 64'(out_log[i].data), 64'(32'h800 + i));
    pm = 100;

    // Reset after beat 2 of a 5-beat s1 packet; s0 must win afterwards.
    do_reset(2);
    for (int i = 0; i < 5; i++) src1_q.push_back(mk(DATAW'(32'h100 + i), i == 4));
    refresh(1'b0, 1'b0);
    n = 0;
    while (src1_q.size() > 3 && n < 50) begin
      cycle();
      n++;
    end
    chk("t4_s1_taken", 64'(src1_q.size()), 64'd3);
    do_reset(1);
    chk("t4_m0_tvalid", 64'(m0_axis_tvalid), 64'd0);
    out_log.delete();
    for (int i = 0; i < 3; i++) begin
      src0_q.push_back(mk(DATAW'(32'h200 + i), i == 2));
      src1_q.push_back(mk(DATAW'(32'h300 + i), i == 2));
    end
    refresh(1'b0, 1'b0);
    drain("t4", 100);
    chk("t4_count", 64'(out_log.size()), 64'd6);
    chk("t4_first_tid", 64'(out_log[0].tid), 64'd0);
    chk("t4_first_data", 64'(out_log[0].data), 64'h200);

    // Randomized traffic.
    tag0 = 0;
    tag1 = 0;
    for (int r = 0; r < 60; r++) begin
      p0 = $urandom_range(100, 30);
      p1 = $urandom_range(100, 30);
      pm = $urandom_range(100, 20);
      for (int k = $urandom_range(2); k > 0; k--) begin
        n = $urandom_range(5, 1);
        for (int i = 0; i < n; i++) begin
          src0_q.push_back(mk(DATAW'(32'h10000 + tag0), i == n - 1));
          tag0++;
        end
      end
      for (int k = $urandom_range(2); k > 0; k--) begin
        n = $urandom_range(5, 1);
        for (int i = 0; i < n; i++) begin
          src1_q.push_back(mk(DATAW'(32'h20000 + tag1), i == n - 1));
          tag1++;
        end
      end
      refresh(1'b0, 1'b0);
      drain("rand", 500);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
